// File: rtl/sts_pkt_framer.sv
// -----------------------------------------------------------------------------
// sts_pkt_framer
//   Framing stage behind the 32->16 bit ST width converter. Each incoming
//   Avalon-ST packet is re-emitted as:
//     header  {HDR_TAG, seq}         (sop)
//     payload (zero-latency pass-through, no bubbles)
//     trailer {empty, beat_count}    (eop unless checksum is compiled in)
//     sum     16-bit payload sum     (eop, only with STS_FRAMER_CHECKSUM_EN)
//   Beats that arrive outside a packet are accepted and counted as drops.
//
// Build option: define STS_FRAMER_CHECKSUM_EN to add the checksum beat.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   data_in_*                16-bit Avalon-ST sink (ready latency 0)
//   data_out_*               16-bit Avalon-ST source (ready latency 0)
//   drop_cnt                 saturating count of beats discarded in IDLE
// -----------------------------------------------------------------------------
module sts_pkt_framer #(
    parameter logic [7:0] HDR_TAG  = 8'hA5,
    parameter logic [7:0] SEQ_INIT = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_in_data,
    output logic        data_in_ready,
    input  logic        data_in_valid,
    input  logic        data_in_empty,
    input  logic        data_in_startofpacket,
    input  logic        data_in_endofpacket,
    output logic [15:0] data_out_data,
    output logic        data_out_empty,
    output logic        data_out_startofpacket,
    output logic        data_out_endofpacket,
    input  logic        data_out_ready,
    output logic        data_out_valid,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAY,
`ifdef STS_FRAMER_CHECKSUM_EN
        S_SUM,
`endif
        S_TRL
    } state_t;

    function automatic logic [14:0] sat_inc15(input logic [14:0] v);
        return (v == 15'h7FFF) ? v : v + 15'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t      state;
    logic [7:0]  seq;
    logic [14:0] cnt;
    logic [7:0]  drop_cnt_q;
    logic        run_p0;        // low during reset and for the first cycle after it
    logic [15:0] out_data_p0;   // registered source beat for HDR/TRL/SUM
    logic        vld_p0;
    logic        out_sop_p0;
    logic        out_eop_p0;
`ifdef STS_FRAMER_CHECKSUM_EN
    logic [15:0] sum;
`endif

    logic in_xfer;
    logic out_xfer;
    logic [14:0] cnt_nxt;

    // Source side: payload is passed straight through, framing beats come from registers.
    always_comb begin
        data_out_data          = out_data_p0;
        data_out_valid         = vld_p0;
        data_out_startofpacket = out_sop_p0;
        data_out_endofpacket   = out_eop_p0;
        data_out_empty         = 1'b0;
        data_in_ready          = 1'b0;
        case (state)
            S_IDLE: data_in_ready = run_p0 & ~(data_in_valid & data_in_startofpacket);
            S_PAY: begin
                data_out_data          = data_in_data;
                data_out_valid         = data_in_valid;
                data_out_startofpacket = 1'b0;
                data_out_endofpacket   = 1'b0;
                data_in_ready          = data_out_ready;
            end
            default: data_in_ready = 1'b0;
        endcase
    end

    assign in_xfer  = data_in_valid & data_in_ready;
    assign out_xfer = data_out_valid & data_out_ready;
    assign cnt_nxt  = sat_inc15(cnt);
    assign drop_cnt = drop_cnt_q;

    // Frame FSM with registered framing beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            seq         <= SEQ_INIT;
            cnt         <= 15'd0;
            drop_cnt_q  <= 8'd0;
            run_p0      <= 1'b0;
            out_data_p0 <= 16'd0;
            vld_p0      <= 1'b0;
            out_sop_p0  <= 1'b0;
            out_eop_p0  <= 1'b0;
`ifdef STS_FRAMER_CHECKSUM_EN
            sum         <= 16'd0;
`endif
        end else begin
            run_p0 <= 1'b1;
            case (state)
                S_IDLE: begin
                    // sop beat is held on the sink until the header has gone out
                    if (run_p0 && data_in_valid && data_in_startofpacket) begin
                        state       <= S_HDR;
                        out_data_p0 <= {HDR_TAG, seq};
                        vld_p0      <= 1'b1;
                        out_sop_p0  <= 1'b1;
                        out_eop_p0  <= 1'b0;
                    end else if (in_xfer) begin
                        drop_cnt_q <= sat_inc8(drop_cnt_q);
                    end
                end
                S_HDR: begin
                    if (out_xfer) begin
                        state      <= S_PAY;
                        seq        <= seq + 8'd1;
                        cnt        <= 15'd0;
                        vld_p0     <= 1'b0;
                        out_sop_p0 <= 1'b0;
`ifdef STS_FRAMER_CHECKSUM_EN
                        sum        <= 16'd0;
`endif
                    end
                end
                S_PAY: begin
                    if (in_xfer) begin
                        cnt <= cnt_nxt;
`ifdef STS_FRAMER_CHECKSUM_EN
                        sum <= sum + data_in_data;
`endif
                        if (data_in_endofpacket) begin
                            state       <= S_TRL;
                            out_data_p0 <= {data_in_empty, cnt_nxt};
                            vld_p0      <= 1'b1;
`ifdef STS_FRAMER_CHECKSUM_EN
                            out_eop_p0  <= 1'b0;
`else
                            out_eop_p0  <= 1'b1;
`endif
                        end
                    end
                end
                S_TRL: begin
                    if (out_xfer) begin
`ifdef STS_FRAMER_CHECKSUM_EN
                        state       <= S_SUM;
                        out_data_p0 <= sum;
                        out_eop_p0  <= 1'b1;
`else
                        state      <= S_IDLE;
                        vld_p0     <= 1'b0;
                        out_eop_p0 <= 1'b0;
`endif
                    end
                end
`ifdef STS_FRAMER_CHECKSUM_EN
                S_SUM: begin
                    if (out_xfer) begin
                        state      <= S_IDLE;
                        vld_p0     <= 1'b0;
                        out_eop_p0 <= 1'b0;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
